// File: rtl/time_set_pkg.sv
// Shared types and default timing constants for the time-setting controller.
package time_set_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } mode_t;

  localparam int unsigned HOLD_CYC_DEF    = 50_000_000;
  localparam int unsigned REPEAT_CYC_DEF  = 10_000_000;
  localparam int unsigned BLINK_CYC_DEF   = 25_000_000;
  localparam int unsigned TIMEOUT_CYC_DEF = 1_000_000_000;

  // Counter width for a count of n cycles; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/time_set_ctl_auto_repeat.sv
// Button edge detector with hold-to-auto-repeat; pulse is combinational for the
// parent to register. Dropping en while held disarms until the button is released.
module auto_repeat
  import time_set_pkg::*;
#(
  parameter int unsigned HOLD_CYC   = HOLD_CYC_DEF,
  parameter int unsigned REPEAT_CYC = REPEAT_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic btn,
  output logic pulse
);

  localparam int unsigned CW = cnt_w((HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYC - 1);

  logic          r_prev;
  logic          r_active;
  logic          r_rep;
  logic [CW-1:0] r_cnt;
  logic          w_rise;
  logic          w_due;

  always_comb begin
    w_rise = btn & ~r_prev;
    w_due  = r_active & (r_cnt == (r_rep ? REP_LAST : HOLD_LAST));
    pulse  = en & btn & (w_rise | w_due);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_prev   <= 1'b0;
      r_active <= 1'b0;
      r_rep    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_prev <= btn;
      if (!en || !btn) begin
        r_active <= 1'b0;
        r_rep    <= 1'b0;
        r_cnt    <= '0;
      end else if (w_rise) begin
        r_active <= 1'b1;
        r_rep    <= 1'b0;
        r_cnt    <= '0;
      end else if (r_active) begin
        if (w_due) begin
          r_cnt <= '0;
          r_rep <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/time_set_ctl.sv
// Mode FSM, inactivity timeout, blink mask and adv pulse steering for
// setting the digital clock from two debounced buttons.
module time_set_ctl
  import time_set_pkg::*;
#(
  parameter int unsigned HOLD_CYC    = HOLD_CYC_DEF,
  parameter int unsigned REPEAT_CYC  = REPEAT_CYC_DEF,
  parameter int unsigned BLINK_CYC   = BLINK_CYC_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic       adv_hr,
  output logic       adv_min,
  output logic       sec_clr,
  output logic       run_en,
  output logic [7:0] digit_blank,
  output logic [1:0] mode
);

  localparam int unsigned TW = cnt_w(TIMEOUT_CYC);
  localparam int unsigned BW = cnt_w(BLINK_CYC);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_CYC - 1);

  mode_t         r_state;
  mode_t         w_next;
  logic          r_mode_prev;
  logic          r_inc_prev;
  logic [TW-1:0] r_to_cnt;
  logic [BW-1:0] r_blk_cnt;
  logic          r_phase;
  logic          w_mode_rise, w_inc_rise, w_in_set, w_timeout, w_change;
  logic          w_en, w_pulse, w_phase_next;
  logic [7:0]    w_blank;

  always_comb begin
    w_mode_rise = btn_mode & ~r_mode_prev;
    w_inc_rise  = btn_inc & ~r_inc_prev;
    w_in_set    = (r_state != RUN);
    // A button edge restarts the inactivity window, so it also vetoes a timeout.
    w_timeout   = w_in_set & (r_to_cnt == TO_LAST) & ~w_mode_rise & ~w_inc_rise;
    w_next      = r_state;
    if (w_mode_rise) begin
      unique case (r_state)
        RUN:     w_next = SET_HR;
        SET_HR:  w_next = SET_MIN;
        default: w_next = RUN;
      endcase
    end else if (w_timeout) begin
      w_next = RUN;
    end
    w_change = (w_next != r_state);
    w_en     = w_in_set & ~w_change;

    w_phase_next = r_phase;
    if (w_change)                    w_phase_next = 1'b0;
    else if (r_blk_cnt == BLK_LAST)  w_phase_next = ~r_phase;

    w_blank = '0;
    if (!btn_inc) begin
      unique case (w_next)
        SET_HR:  w_blank[7:6] = {2{w_phase_next}};
        SET_MIN: w_blank[5:4] = {2{w_phase_next}};
        default: w_blank = '0;
      endcase
    end
  end

  auto_repeat #(
    .HOLD_CYC  (HOLD_CYC),
    .REPEAT_CYC(REPEAT_CYC)
  ) u_repeat (
    .clk  (clk),
    .rst  (rst),
    .en   (w_en),
    .btn  (btn_inc),
    .pulse(w_pulse)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= RUN;
      r_mode_prev <= 1'b0;
      r_inc_prev  <= 1'b0;
      r_to_cnt    <= '0;
      r_blk_cnt   <= '0;
      r_phase     <= 1'b0;
      adv_hr      <= 1'b0;
      adv_min     <= 1'b0;
      sec_clr     <= 1'b0;
      run_en      <= 1'b1;
      digit_blank <= '0;
    end else begin
      r_state     <= w_next;
      r_mode_prev <= btn_mode;
      r_inc_prev  <= btn_inc;
      adv_hr      <= w_pulse & (r_state == SET_HR);
      adv_min     <= w_pulse & (r_state == SET_MIN);
      sec_clr     <= w_change & (w_next == RUN);
      run_en      <= (w_next == RUN);
      digit_blank <= w_blank;
      if (!w_in_set || w_change || w_mode_rise || w_inc_rise || w_pulse)
        r_to_cnt <= '0;
      else
        r_to_cnt <= r_to_cnt + TW'(1);
      if (w_change || (r_blk_cnt == BLK_LAST))
        r_blk_cnt <= '0;
      else
        r_blk_cnt <= r_blk_cnt + BW'(1);
      r_phase <= w_phase_next;
    end
  end

  assign mode = r_state;

endmodule

// File: tb/tb_time_set_ctl.sv
// Scoreboard bench for time_set_ctl: a time-stamp based reference model queues the
// expected outputs each clock; a monitor pops and compares them on the falling edge.
module tb_time_set_ctl;

  localparam int unsigned HOLD    = 20;
  localparam int unsigned REPEAT  = 5;
  localparam int unsigned BLINK   = 8;
  localparam int unsigned TIMEOUT = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       adv_hr, adv_min, sec_clr, run_en;
  logic [7:0] digit_blank;
  logic [1:0] mode;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic       adv_hr;
    logic       adv_min;
    logic       sec_clr;
    logic       run_en;
    logic [7:0] blank;
    logic [1:0] mode;
  } obs_t;

  obs_t q_exp[$];

  time_set_ctl #(
    .HOLD_CYC   (HOLD),
    .REPEAT_CYC (REPEAT),
    .BLINK_CYC  (BLINK),
    .TIMEOUT_CYC(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .adv_hr     (adv_hr),
    .adv_min    (adv_min),
    .sec_clr    (sec_clr),
    .run_en     (run_en),
    .digit_blank(digit_blank),
    .mode       (mode)
  );

  always #5 clk = ~clk;

  // Reference model: tracks the cycle of the current press, of the last activity
  // and of entry into the current SET state, and derives outputs arithmetically.
  longint k = 0;
  int     m_state = 0;
  bit     m_pm = 0, m_pi = 0, m_press = 0;
  longint m_press_k = 0, m_last_act = 0, m_entry = 0;

  always @(posedge clk) begin
    obs_t   e;
    bit     mr, ir, tmo, ch, en, fire, ph;
    int     nx;
    longint age;
    e = '0;
    if (!rst) begin
      m_state = 0; m_pm = 0; m_pi = 0; m_press = 0;
      e.run_en = 1'b1;
    end else begin
      mr  = btn_mode && !m_pm;
      ir  = btn_inc && !m_pi;
      tmo = (m_state != 0) && (k - m_last_act == TIMEOUT) && !mr && !ir;
      nx  = mr ? (m_state + 1) % 3 : (tmo ? 0 : m_state);
      ch  = (nx != m_state);
      en  = (m_state != 0) && !ch;
      if (!btn_inc || !en) m_press = 0;
      else if (ir) begin m_press = 1; m_press_k = k; end
      age  = k - m_press_k;
      fire = m_press && (age == 0 || age == HOLD ||
                         (age > HOLD && (age - HOLD) % REPEAT == 0));
      if (ch || mr || ir || fire) m_last_act = k;
      if (ch) m_entry = k;
      ph = ((k - m_entry) / BLINK) % 2 == 1;
      e.adv_hr  = fire && (m_state == 1);
      e.adv_min = fire && (m_state == 2);
      e.sec_clr = ch && (nx == 0);
      e.run_en  = (nx == 0);
      e.mode    = 2'(nx);
      if (!btn_inc && nx == 1) e.blank = ph ? 8'hC0 : 8'h00;
      if (!btn_inc && nx == 2) e.blank = ph ? 8'h30 : 8'h00;
      m_pm = btn_mode; m_pi = btn_inc; m_state = nx;
    end
    k++;
    q_exp.push_back(e);
  end

  always @(negedge clk) begin
    obs_t e, a;
    if (q_exp.size() != 0) begin
      e = q_exp.pop_front();
      a = '{adv_hr, adv_min, sec_clr, run_en, digit_blank, mode};
      n_vec++;
      if (a !== e) begin
        n_err++;
        $display("FAIL outputs @%0t: got hr=%b min=%b clr=%b run=%b blank=%h mode=%0d, want hr=%b min=%b clr=%b run=%b blank=%h mode=%0d",
                 $time, a.adv_hr, a.adv_min, a.sec_clr, a.run_en, a.blank, a.mode,
                 e.adv_hr, e.adv_min, e.sec_clr, e.run_en, e.blank, e.mode);
      end
    end
  end

  task automatic drive(input bit m, input bit i, input int n);
    btn_mode = m;
    btn_inc  = i;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_mode();
    drive(1, 0, 1);
    drive(0, 0, 3);
  endtask

  initial begin
    // reset, then inc presses in RUN
    drive(0, 0, 3);
    rst = 1'b1;
    for (int j = 0; j < 3; j++) begin
      drive(0, 1, 2);
      drive(0, 0, 2);
    end
    // mode cycle, then a long mode hold advancing one step
    for (int j = 0; j < 3; j++) press_mode();
    drive(1, 0, 50);
    drive(0, 0, 3);
    // SET_HR hold-to-repeat
    drive(0, 1, 41);
    drive(0, 0, 3);
    // same-edge mode+inc, held inc across the change, then a fresh press
    drive(1, 1, 1);
    drive(0, 1, 10);
    drive(0, 0, 2);
    drive(0, 1, 3);
    drive(0, 0, 1);
    // idle in SET_MIN: blink then timeout
    drive(0, 0, 110);
    // reset in the middle of auto-repeat in SET_MIN
    press_mode();
    press_mode();
    drive(0, 1, 30);
    rst = 1'b0;
    drive(0, 1, 1);
    rst = 1'b1;
    drive(0, 1, 5);
    drive(0, 0, 3);
    // randomized segments
    for (int s = 0; s < 160; s++) begin
      if ($urandom_range(0, 40) == 0) begin
        rst = 1'b0;
        drive(0, 0, 1);
        rst = 1'b1;
      end
      drive(bit'($urandom_range(0, 5) == 0), bit'($urandom_range(0, 1)),
            int'($urandom_range(1, 60)));
    end
    drive(0, 0, 2);
    @(negedge clk);
    #1;
    n_vec++;
    if (q_exp.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, want 0", q_exp.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
